slave_mem_ctrl: RTL



---
 rtl/slave_mem_pkg.sv | 23 ++
 rtl/slave_mem_ctrl_sp_ram.sv | 27 ++
 rtl/slave_mem_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/slave_mem_pkg.sv
// Shared definitions for the memory-side controller behind the serial bus slave:
// default widths, the latency bound, the controller state encoding and counter type.
package slave_mem_pkg;

  localparam int DEFAULT_ADDRESS_WIDTH  = 15;
  localparam int DEFAULT_DATA_WIDTH     = 8;
  localparam int DEFAULT_MEM_DEPTH      = 4096;
  localparam int DEFAULT_ACCESS_LATENCY = 4;

  // Largest supported access latency; sizes the countdown counter.
  localparam int MAX_LATENCY = 15;
  localparam int COUNT_WIDTH = $clog2(MAX_LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE_WAIT = 2'd1,
    READ_WAIT  = 2'd2,
    DONE       = 2'd3
  } ctrl_state_t;

  typedef logic [COUNT_WIDTH-1:0] count_t;

endpackage

// File: rtl/slave_mem_ctrl_sp_ram.sv
// Synchronous single-port RAM with one-cycle read latency and no reset.
// The read is read-first: dout shows the old word during a write cycle.
module sp_ram
  import slave_mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int MEM_DEPTH  = DEFAULT_MEM_DEPTH,
  parameter int ADDR_WIDTH = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Registered read of the addressed word, with an optional write of the same word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
    dout <= mem[addr];
  end

endmodule

// File: rtl/slave_mem_ctrl.sv
// Memory-side controller for the serial bus slave. Accepts single-beat write or
// read requests, waits a fixed access latency, touches the on-chip RAM one cycle
// before completion and returns a one-cycle dv pulse. Out-of-range addresses and
// simultaneous write/read requests are flagged.
module slave_mem_ctrl
  import slave_mem_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = DEFAULT_ADDRESS_WIDTH,
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int MEM_DEPTH      = DEFAULT_MEM_DEPTH,
  parameter int ACCESS_LATENCY = DEFAULT_ACCESS_LATENCY
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     write_en,
  input  logic                     req_data,
  input  logic [ADDRESS_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0]    data_in,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     dv,
  output logic                     busy,
  output logic                     err_addr,
  output logic                     collision
);

  localparam int INDEX_WIDTH = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  // One extra bit so that a depth equal to 2**ADDRESS_WIDTH still compares correctly.
  localparam logic [ADDRESS_WIDTH:0] DEPTH_LIMIT = (ADDRESS_WIDTH + 1)'(MEM_DEPTH);
  localparam count_t LOAD_VALUE = count_t'(ACCESS_LATENCY - 1);
  localparam count_t ISSUE_VALUE = count_t'(1);

  ctrl_state_t state;
  ctrl_state_t state_next;
  count_t      count;

  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    data_q;
  logic [DATA_WIDTH-1:0]    ram_dout;
  logic                     ram_we;
  logic                     out_of_range;
  logic                     start_write;
  logic                     start_read;
  logic                     wait_done;

  // A write wins over a simultaneous read; requests outside IDLE are dropped.
  assign start_write  = (state == IDLE) && write_en;
  assign start_read   = (state == IDLE) && req_data && !write_en;
  assign wait_done    = ((state == WRITE_WAIT) || (state == READ_WAIT)) && (count == '0);
  assign out_of_range = ({1'b0, addr_q} >= DEPTH_LIMIT);

  // State register; reset abandons any request in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state selection: start on a request, finish when the countdown expires.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_write) begin
          state_next = WRITE_WAIT;
        end else if (start_read) begin
          state_next = READ_WAIT;
        end
      end
      WRITE_WAIT, READ_WAIT: begin
        if (count == '0) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from the state; the RAM write fires one cycle before DONE.
  always_comb begin
    dv       = (state == DONE);
    busy     = (state == WRITE_WAIT) || (state == READ_WAIT);
    err_addr = (state == DONE) && out_of_range;
    ram_we   = (state == WRITE_WAIT) && (count == ISSUE_VALUE) && !out_of_range;
  end

  // Request capture and access-latency countdown.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count  <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else if (start_write || start_read) begin
      count  <= LOAD_VALUE;
      addr_q <= addr;
      if (start_write) begin
        data_q <= data_in;
      end
    end else if (((state == WRITE_WAIT) || (state == READ_WAIT)) && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  // Read data is captured as the read enters DONE and held until the next read.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_out <= '0;
    end else if (wait_done && (state == READ_WAIT)) begin
      data_out <= out_of_range ? '0 : ram_dout;
    end
  end

  // Collision pulse one cycle after an accepted edge carrying both requests.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      collision <= 1'b0;
    end else begin
      collision <= (state == IDLE) && write_en && req_data;
    end
  end

  sp_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_WIDTH(INDEX_WIDTH)
  ) u_ram (
    .clk (clk),
    .we  (ram_we),
    .addr(addr_q[INDEX_WIDTH-1:0]),
    .din (data_q),
    .dout(ram_dout)
  );

endmodule
